// File: rtl/xor_stream_pkg.sv
// Shared constants and keystream helper for the XOR stream unit.
package xor_stream_pkg;

  localparam int unsigned WIDTH_D  = 8;
  localparam int unsigned LFSR_W_D = 16;
  localparam logic [15:0] TAPS_D   = 16'hB400;
  localparam logic [15:0] SEED_D   = 16'hACE1;

  // ks occupies the upper half, state the lower half of the packed result
  typedef struct packed {
    logic [63:0] ks;
    logic [63:0] state;
  } lfsr_res_t;

  // Step a Galois LFSR nsteps times, collecting the output bit of each step.
  function automatic lfsr_res_t lfsr_advance(input logic [63:0] state,
                                             input logic [63:0] taps,
                                             input int unsigned nsteps);
    lfsr_res_t   res;
    logic [63:0] s;
    logic        fb;
    res.ks = '0;
    s      = state;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i < nsteps) begin
        fb        = s[0];
        res.ks[i] = fb;
        s         = (s >> 1) ^ (fb ? taps : 64'd0);
      end
    end
    res.state = s;
    return res;
  endfunction

endpackage

// File: rtl/xor_keystream_gen.sv
// Galois LFSR keystream generator: presents one WIDTH-bit keystream word per state.
module xor_keystream_gen
  import xor_stream_pkg::*;
#(
  parameter int unsigned       WIDTH  = WIDTH_D,
  parameter int unsigned       LFSR_W = LFSR_W_D,
  parameter logic [LFSR_W-1:0] TAPS   = TAPS_D,
  parameter logic [LFSR_W-1:0] SEED   = SEED_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_value,
  output logic [WIDTH-1:0]  ks
);

  logic [LFSR_W-1:0] state_q, state_d, state_next;

  // Keystream word and post-word state from the current state; the casts keep
  // only the live low bits of each 64-bit half.
  always_comb begin
    ks         = WIDTH'(lfsr_advance(64'(state_q), 64'(TAPS), WIDTH) >> 64);
    state_next = LFSR_W'(lfsr_advance(64'(state_q), 64'(TAPS), WIDTH));
  end

  // Load wins over advance; a zero seed would lock the LFSR, so SEED replaces it.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = (load_value == '0) ? SEED : load_value;
    end else if (advance) begin
      state_d = state_next;
    end
  end

  // LFSR state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/xor_stream.sv
// Flow-controlled XOR scrambler/descrambler with a single registered output stage.
module xor_stream
  import xor_stream_pkg::*;
#(
  parameter int unsigned       WIDTH  = WIDTH_D,
  parameter int unsigned       LFSR_W = LFSR_W_D,
  parameter logic [LFSR_W-1:0] TAPS   = TAPS_D,
  parameter logic [LFSR_W-1:0] SEED   = SEED_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              bypass,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [31:0]       word_cnt
);

  logic             accept;
  logic [WIDTH-1:0] ks;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [31:0]      word_cnt_q, word_cnt_d;

  // Handshake: a seed load blocks input so the next word sees the new keystream.
  always_comb begin
    in_ready = !seed_load && (!out_valid_q || out_ready);
    accept   = in_valid && in_ready;
  end

  xor_keystream_gen #(
    .WIDTH (WIDTH),
    .LFSR_W(LFSR_W),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_keystream (
    .clk       (clk),
    .rst       (rst),
    .advance   (accept && !bypass),
    .load      (seed_load),
    .load_value(seed),
    .ks        (ks)
  );

  // Output stage and word counter next state.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    word_cnt_d  = word_cnt_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = bypass ? in_data : (in_data ^ ks);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (seed_load) begin
      word_cnt_d = '0;
    end else if (accept) begin
      word_cnt_d = word_cnt_q + 32'd1;
    end
  end

  // Output register and counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      word_cnt_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign word_cnt  = word_cnt_q;

endmodule
